// File: rtl/axi_burst_rd_slave.sv
// AXI4 read-channel responder backed by a backdoor-loadable word memory.
// Define AXI_RD_DELAY_EN to add first-beat latency (WAIT state) and LFSR-paced beat gaps.
module axi_burst_rd_slave #(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
  parameter int          FIRST_LAT = 3,
  parameter logic [15:0] LFSR_SEED = 16'hace1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  // state | meaning
  // IDLE  | ready for one AR request
  // WAIT  | first-beat latency (AXI_RD_DELAY_EN only)
  // BURST | presenting beats until the last one is accepted
  localparam logic [1:0] IDLE  = 2'd0;
`ifdef AXI_RD_DELAY_EN
  localparam logic [1:0] WAIT  = 2'd1;
`endif
  localparam logic [1:0] BURST = 2'd2;

  localparam logic [31:0] WIN_BYTES = 32'd4 << MEM_AW;

  logic [31:0] mem [2**MEM_AW];

  logic [1:0]  state;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  beat_cnt;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        hs;
  logic        last_hs;
  logic        gate;
  logic [31:0] next_addr;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [1:0]  sel_burst;
  logic [31:0] off;
  logic        beat_err;
  logic [31:0] beat_data;

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign hs        = rvalid_q && rready;
  assign last_hs   = hs && (beat_cnt == len_q);
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  // Beat data is registered when presented, so a same-cycle backdoor write is not seen.
  always_comb begin
    sel_addr  = addr_q;
    sel_size  = size_q;
    sel_burst = burst_q;
    if (state == IDLE) begin
      sel_addr  = araddr;
      sel_size  = arsize;
      sel_burst = arburst;
    end else if (hs) begin
      sel_addr = next_addr;
    end
    off       = sel_addr - BASE_ADDR;
    beat_err  = (off >= WIN_BYTES) || (sel_size > 3'd2) || sel_burst[1];
    beat_data = beat_err ? 32'd0 : mem[off[MEM_AW+1:2]];
  end

`ifdef AXI_RD_DELAY_EN
  logic [15:0] lfsr;
  logic [7:0]  wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign gate = lfsr[0];
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, 32'(FIRST_LAT)};
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
`ifdef AXI_RD_DELAY_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arvalid) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            beat_cnt <= '0;
`ifdef AXI_RD_DELAY_EN
            if (FIRST_LAT == 0) begin
              state <= BURST;
            end else begin
              state    <= WAIT;
              wait_cnt <= 8'(FIRST_LAT - 1);
            end
`else
            state    <= BURST;
            rvalid_q <= 1'b1;
            rdata_q  <= beat_data;
            rresp_q  <= beat_err ? 2'b10 : 2'b00;
`endif
          end
        end
`ifdef AXI_RD_DELAY_EN
        WAIT: begin
          if (wait_cnt == 8'd0) state <= BURST;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
`endif
        BURST: begin
          if (last_hs) begin
            state    <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
          end else begin
            if (hs) begin
              beat_cnt <= beat_cnt + 8'd1;
              addr_q   <= next_addr;
            end
            // A pending beat stays put until accepted; a new one appears only when gated in.
            if (hs || !rvalid_q) begin
              if (gate) begin
                rvalid_q <= 1'b1;
                rdata_q  <= beat_data;
                rresp_q  <= beat_err ? 2'b10 : 2'b00;
              end else begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
                rresp_q  <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arready = (state == IDLE);
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rvalid_q && (beat_cnt == len_q);
  assign rid     = id_q;

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// Scoreboard bench for axi_burst_rd_slave: directed bursts, stalls, errors and mid-burst reset.
module tb_axi_burst_rd_slave;

  localparam logic [31:0] BASE = 32'h1fc0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  axi_burst_rd_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted beat is compared against the oldest expectation.
  beat_t e;
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat got rdata=%h expected no beat", rdata);
      end else begin
        e = sb.pop_front();
        chk("beat_rdata", rdata, e.data);
        chk("beat_rresp", 32'(rresp), 32'(e.resp));
        chk("beat_rlast", 32'(rlast), 32'(e.last));
        chk("beat_rid", 32'(rid), 32'(e.id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 12'(a);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    beat_t b;
    b.data = d; b.resp = r; b.last = l; b.id = id;
    sb.push_back(b);
  endtask

  task automatic push_seq(input logic [3:0] id, input logic [31:0] d0, input int n, input logic fixed);
    for (int i = 0; i < n; i++)
      push(fixed ? d0 : d0 + 32'(i), 2'b00, i == n - 1, id);
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt);
    int n;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (arready) break;
      n++;
      if (n > 50) begin
        chk("ar_accept_timeout", 32'(arready), 32'd1);
        break;
      end
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arvalid = 1'b0; rready = 1'b0; ld_en = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    ld_addr = '0; ld_data = '0;
    tick();
    for (int i = 0; i < 8; i++) load(8 + i, 32'h1000_0000 + 32'(i));
    load(4095, 32'hcafe_f00d);
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;

    // INCR burst of 8, rready held high
    rready = 1'b1;
    push_seq(4'h5, 32'h1000_0000, 8, 1'b0);
    issue(4'h5, BASE + 32'h20, 8'd7, 3'd2, 2'b01);
`ifndef AXI_RD_DELAY_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_rvalid_consecutive", 32'(rvalid), 32'd1);
      if (k == 0) chk("t1_arready_busy", 32'(arready), 32'd0);
    end
`endif
    drain("t1_drain");
    @(negedge clk);
    chk("t1_arready_after", 32'(arready), 32'd1);
    tick();

    // Same burst with a 4-cycle stall on the third beat
    push_seq(4'h3, 32'h1000_0000, 8, 1'b0);
    issue(4'h3, BASE + 32'h20, 8'd7, 3'd2, 2'b01);
    tick();
    tick();
    rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifndef AXI_RD_DELAY_EN
      @(negedge clk);
      chk("t2_hold_rvalid", 32'(rvalid), 32'd1);
      chk("t2_hold_rdata", rdata, 32'h1000_0002);
      chk("t2_hold_rlast", 32'(rlast), 32'd0);
`endif
      tick();
    end
    rready = 1'b1;
    drain("t2_drain");

    // FIXED burst of 4 from word 9
    push_seq(4'h7, 32'h1000_0001, 4, 1'b1);
    issue(4'h7, BASE + 32'h24, 8'd3, 3'd2, 2'b00);
    drain("t3_drain");

    // Last word then one past the window
    push(32'hcafe_f00d, 2'b00, 1'b0, 4'h2);
    push(32'd0, 2'b10, 1'b1, 4'h2);
    issue(4'h2, BASE + 32'h3ffc, 8'd1, 3'd2, 2'b01);
    drain("t4_drain");

    // arsize too large, unsupported burst type, address below the window
    push(32'd0, 2'b10, 1'b0, 4'h1);
    push(32'd0, 2'b10, 1'b1, 4'h1);
    issue(4'h1, BASE + 32'h20, 8'd1, 3'd3, 2'b01);
    drain("t4b_size_drain");
    push(32'd0, 2'b10, 1'b0, 4'h4);
    push(32'd0, 2'b10, 1'b1, 4'h4);
    issue(4'h4, BASE + 32'h20, 8'd1, 3'd2, 2'b10);
    drain("t4c_burst_drain");
    push(32'd0, 2'b10, 1'b1, 4'h6);
    issue(4'h6, BASE - 32'h4, 8'd0, 3'd2, 2'b01);
    drain("t4d_below_drain");

    // Reset after three beats, then a fresh burst
    push_seq(4'h9, 32'h1000_0000, 8, 1'b0);
    issue(4'h9, BASE + 32'h20, 8'd7, 3'd2, 2'b01);
    tick();
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_after_rst", 32'(rvalid), 32'd0);
    chk("t5_arready_after_rst", 32'(arready), 32'd1);
    chk("t5_rlast_after_rst", 32'(rlast), 32'd0);
    tick();
    push_seq(4'ha, 32'h1000_0000, 8, 1'b0);
    issue(4'ha, BASE + 32'h20, 8'd7, 3'd2, 2'b01);
    drain("t5_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
